// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and defaults for the instruction fetch stage.
package fetch_pkg;
  localparam int ADDR_W_DEF   = 16;
  localparam int RESET_PC_DEF = 0;
  localparam int TIMEOUT_DEF  = 15;
  localparam int INSTR_W      = 16;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
endpackage

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: instruction ROM read port between fetch stage and ROM.
interface instruction_fetch_if import fetch_pkg::*; #(parameter int ADDR_W = ADDR_W_DEF);
  logic [ADDR_W-1:0]  rom_addr;
  logic               rom_cen;
  logic               rom_ren;
  logic [INSTR_W-1:0] rom_data;
  logic               rom_valid;
  modport master (output rom_addr, rom_cen, rom_ren, input rom_data, rom_valid);
  modport slave  (input rom_addr, rom_cen, rom_ren, output rom_data, rom_valid);
endinterface

// File: rtl/pc_reg.sv
// pc_reg: program counter with wrapping increment, immediate jump load and pending-jump latch.
module pc_reg #(
  parameter int ADDR_W   = 16,
  parameter int RESET_PC = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              idle,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              done,
  input  logic              abandon,
  output logic [ADDR_W-1:0] pc
);
  logic              pend;
  logic [ADDR_W-1:0] tgt;
  // a jump arriving on the closing cycle of a fetch is the newest pending target
  always_ff @(posedge clock) begin
    if (reset) begin
      pc   <= ADDR_W'(RESET_PC);
      pend <= 1'b0;
      tgt  <= '0;
    end else if (idle) begin
      if (jump_en) pc <= jump_target;
    end else if (done || abandon) begin
      pc   <= jump_en ? jump_target : pend ? tgt : done ? pc + 1'b1 : pc;
      pend <= 1'b0;
    end else if (jump_en) begin
      pend <= 1'b1;
      tgt  <= jump_target;
    end
  end
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch FSM issuing ROM reads, capturing the instruction register and link address.
module instruction_fetch import fetch_pkg::*; #(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int RESET_PC = RESET_PC_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               fetch_req,
  input  logic               jump_en,
  input  logic [ADDR_W-1:0]  jump_target,
  input  logic               link_en,
  instruction_fetch_if.master rom,
  output logic [INSTR_W-1:0] instrucao,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  pc_link,
  output logic               busy,
  output logic               fetch_fault
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          done, abandon, cen;
  pc_reg #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc (
    .clock, .reset, .idle(state == IDLE), .jump_en, .jump_target, .done, .abandon, .pc
  );
  assign rom.rom_addr = pc;
  assign rom.rom_cen  = cen;
  assign rom.rom_ren  = cen;
  always_comb begin
    done      = state != IDLE && rom.rom_valid;
    abandon   = state != IDLE && !rom.rom_valid && cnt == CW'(TIMEOUT - 1);
    state_nxt = state == IDLE ? (fetch_req ? REQ : IDLE) : (done || abandon) ? IDLE : WAIT;
  end
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end
  // cen/busy are registered from the next state so they line up with REQ / non-IDLE
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt         <= '0;
      instrucao   <= '0;
      instr_valid <= 1'b0;
      pc_link     <= '0;
      cen         <= 1'b0;
      busy        <= 1'b0;
      fetch_fault <= 1'b0;
    end else begin
      cnt         <= state == IDLE ? '0 : cnt + 1'b1;
      instr_valid <= done;
      cen         <= state_nxt == REQ;
      busy        <= state_nxt != IDLE;
      if (done)    instrucao   <= rom.rom_data;
      if (link_en) pc_link     <= pc;
      if (abandon) fetch_fault <= 1'b1;
    end
  end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed table, corner sequences and randomized run against a transaction-level model.
module tb_instruction_fetch;
  localparam int TIMEOUT = 15;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_req = 1'b0, jump_en = 1'b0, link_en = 1'b0;
  logic [15:0] jump_target = '0;
  logic [15:0] instrucao, pc, pc_link;
  logic        instr_valid, busy, fetch_fault;
  int          n_vec = 0, n_bad = 0;

  instruction_fetch_if #(.ADDR_W(16)) rom_bus ();

  instruction_fetch #(.ADDR_W(16), .RESET_PC(0), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .fetch_req(fetch_req), .jump_en(jump_en),
    .jump_target(jump_target), .link_en(link_en), .rom(rom_bus.master),
    .instrucao(instrucao), .instr_valid(instr_valid), .pc(pc), .pc_link(pc_link),
    .busy(busy), .fetch_fault(fetch_fault)
  );

  always #5 clock = ~clock;

  // model: one outstanding fetch, described by its age in cycles
  logic [15:0] m_pc, m_instr, m_link, m_tgt;
  logic        m_valid, m_busy, m_fault, m_pend;
  int          m_age;

  task automatic chk(input string nm, input logic [15:0] a, input logic [15:0] e);
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic model_step();
    logic [15:0] old;
    old = m_pc;
    if (reset) begin
      m_pc = 0; m_instr = 0; m_link = 0; m_tgt = 0;
      m_valid = 0; m_busy = 0; m_fault = 0; m_pend = 0; m_age = 0;
      return;
    end
    m_valid = 0;
    if (!m_busy) begin
      if (jump_en) m_pc = jump_target;
      if (fetch_req) begin m_busy = 1; m_age = 0; end
    end else begin
      if (jump_en) begin m_pend = 1; m_tgt = jump_target; end
      if (rom_bus.rom_valid) begin
        m_instr = rom_bus.rom_data; m_valid = 1;
        m_pc = m_pend ? m_tgt : old + 16'd1;
        m_pend = 0; m_busy = 0;
      end else if (m_age + 1 == TIMEOUT) begin
        m_fault = 1;
        if (m_pend) m_pc = m_tgt;
        m_pend = 0; m_busy = 0;
      end else m_age++;
    end
    if (link_en) m_link = old;
  endtask

  task automatic tick(input logic r, input logic fr, input logic je, input logic [15:0] jt,
                      input logic le, input logic rv, input logic [15:0] rd);
    logic m_cen;
    reset = r; fetch_req = fr; jump_en = je; jump_target = jt; link_en = le;
    rom_bus.rom_valid = rv; rom_bus.rom_data = rd;
    @(posedge clock); #1;
    model_step();
    m_cen = m_busy && m_age == 0;
    chk("m_pc", pc, m_pc);
    chk("m_rom_addr", rom_bus.rom_addr, m_pc);
    chk("m_instrucao", instrucao, m_instr);
    chk("m_instr_valid", 16'(instr_valid), 16'(m_valid));
    chk("m_pc_link", pc_link, m_link);
    chk("m_busy", 16'(busy), 16'(m_busy));
    chk("m_fetch_fault", 16'(fetch_fault), 16'(m_fault));
    chk("m_rom_cen", 16'(rom_bus.rom_cen), 16'(m_cen));
    chk("m_rom_ren", 16'(rom_bus.rom_ren), 16'(m_cen));
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, " pc"}, pc, 16'h0000);
    chk({tag, " rom_addr"}, rom_bus.rom_addr, 16'h0000);
    chk({tag, " instrucao"}, instrucao, 16'h0000);
    chk({tag, " instr_valid"}, 16'(instr_valid), 16'h0);
    chk({tag, " pc_link"}, pc_link, 16'h0000);
    chk({tag, " busy"}, 16'(busy), 16'h0);
    chk({tag, " rom_cen"}, 16'(rom_bus.rom_cen), 16'h0);
    chk({tag, " fetch_fault"}, 16'(fetch_fault), 16'h0);
  endtask

  typedef struct packed {
    logic fr, je; logic [15:0] jt; logic le, rv; logic [15:0] rd;
    logic [15:0] e_pc, e_instr; logic e_valid, e_busy, e_cen; logic [15:0] e_link;
  } vec_t;

  vec_t tbl [27];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rom_bus.rom_valid = 1'b0;
    rom_bus.rom_data  = '0;
    tbl = '{
      '{1,0,16'h0000,0,0,16'h0000, 16'h0000,16'h0000,0,1,1,16'h0000},
      '{0,0,16'h0000,0,1,16'h8A53, 16'h0001,16'h8A53,1,0,0,16'h0000},
      '{0,0,16'h0000,0,0,16'h0000, 16'h0001,16'h8A53,0,0,0,16'h0000},
      '{1,0,16'h0000,0,0,16'h0000, 16'h0001,16'h8A53,0,1,1,16'h0000},
      '{0,0,16'h0000,0,0,16'h0000, 16'h0001,16'h8A53,0,1,0,16'h0000},
      '{0,0,16'h0000,0,0,16'h0000, 16'h0001,16'h8A53,0,1,0,16'h0000},
      '{0,0,16'h0000,0,0,16'h0000, 16'h0001,16'h8A53,0,1,0,16'h0000},
      '{0,0,16'h0000,0,1,16'h4123, 16'h0002,16'h4123,1,0,0,16'h0000},
      '{0,1,16'h0040,0,0,16'h0000, 16'h0040,16'h4123,0,0,0,16'h0000},
      '{1,0,16'h0000,0,0,16'h0000, 16'h0040,16'h4123,0,1,1,16'h0000},
      '{0,0,16'h0000,0,1,16'h1111, 16'h0041,16'h1111,1,0,0,16'h0000},
      '{1,0,16'h0000,0,0,16'h0000, 16'h0041,16'h1111,0,1,1,16'h0000},
      '{0,0,16'h0000,0,0,16'h0000, 16'h0041,16'h1111,0,1,0,16'h0000},
      '{0,1,16'h0100,0,0,16'h0000, 16'h0041,16'h1111,0,1,0,16'h0000},
      '{0,0,16'h0000,0,1,16'h2222, 16'h0100,16'h2222,1,0,0,16'h0000},
      '{0,1,16'hFFFF,0,0,16'h0000, 16'hFFFF,16'h2222,0,0,0,16'h0000},
      '{1,0,16'h0000,0,0,16'h0000, 16'hFFFF,16'h2222,0,1,1,16'h0000},
      '{0,0,16'h0000,0,1,16'h3333, 16'h0000,16'h3333,1,0,0,16'h0000},
      '{0,1,16'h0012,0,0,16'h0000, 16'h0012,16'h3333,0,0,0,16'h0000},
      '{0,0,16'h0000,1,0,16'h0000, 16'h0012,16'h3333,0,0,0,16'h0012},
      '{0,1,16'h0050,1,0,16'h0000, 16'h0050,16'h3333,0,0,0,16'h0012},
      '{1,1,16'h0200,0,0,16'h0000, 16'h0200,16'h3333,0,1,1,16'h0012},
      '{0,0,16'h0000,0,1,16'h4444, 16'h0201,16'h4444,1,0,0,16'h0012},
      '{1,0,16'h0000,0,0,16'h0000, 16'h0201,16'h4444,0,1,1,16'h0012},
      '{1,0,16'h0000,0,0,16'h0000, 16'h0201,16'h4444,0,1,0,16'h0012},
      '{0,0,16'h0000,0,1,16'h5555, 16'h0202,16'h5555,1,0,0,16'h0012},
      '{0,0,16'h0000,0,1,16'hDEAD, 16'h0202,16'h5555,0,0,0,16'h0012}
    };
    tick(1, 0, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0, 0);
    chk_reset_values("reset");
    foreach (tbl[i]) begin
      tick(0, tbl[i].fr, tbl[i].je, tbl[i].jt, tbl[i].le, tbl[i].rv, tbl[i].rd);
      chk($sformatf("row%0d pc", i), pc, tbl[i].e_pc);
      chk($sformatf("row%0d rom_addr", i), rom_bus.rom_addr, tbl[i].e_pc);
      chk($sformatf("row%0d instrucao", i), instrucao, tbl[i].e_instr);
      chk($sformatf("row%0d instr_valid", i), 16'(instr_valid), 16'(tbl[i].e_valid));
      chk($sformatf("row%0d busy", i), 16'(busy), 16'(tbl[i].e_busy));
      chk($sformatf("row%0d rom_cen", i), 16'(rom_bus.rom_cen), 16'(tbl[i].e_cen));
      chk($sformatf("row%0d pc_link", i), pc_link, tbl[i].e_link);
    end
    // timeout: fetch abandoned after TIMEOUT cycles in REQ+WAIT
    tick(0, 1, 0, 0, 0, 0, 0);
    for (int i = 1; i < TIMEOUT; i++) begin
      tick(0, 0, 0, 0, 0, 0, 0);
      chk("timeout busy", 16'(busy), 16'h1);
      chk("timeout early fault", 16'(fetch_fault), 16'h0);
    end
    tick(0, 0, 0, 0, 0, 0, 0);
    chk("timeout idle", 16'(busy), 16'h0);
    chk("timeout fault", 16'(fetch_fault), 16'h1);
    chk("timeout pc", pc, 16'h0202);
    chk("timeout instrucao", instrucao, 16'h5555);
    chk("timeout instr_valid", 16'(instr_valid), 16'h0);
    tick(0, 1, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 1, 16'h6666);
    chk("post-timeout pc", pc, 16'h0203);
    chk("post-timeout instrucao", instrucao, 16'h6666);
    chk("post-timeout valid", 16'(instr_valid), 16'h1);
    chk("fault sticky", 16'(fetch_fault), 16'h1);
    // reset during WAIT, ROM answers one cycle later
    tick(0, 1, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 0);
    chk("in WAIT", 16'(busy), 16'h1);
    tick(1, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 1, 16'hBEEF);
    chk_reset_values("reset-in-wait");
    tick(0, 0, 0, 0, 0, 0, 0);
    chk("late valid ignored", 16'(instr_valid), 16'h0);
    // randomized run; second half starves the ROM to provoke timeouts
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] jt;
      int          rv_thr;
      jt     = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      rv_thr = (i < 1500) ? 3 : 1;
      tick($urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, jt,
           $urandom_range(0, 7) == 0, $urandom_range(0, 9) < rv_thr, 16'($urandom));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage of the 16-bit multicycle core, directly upstream of the control unit. Holds the program counter, issues one read per fetch request to the instruction ROM, captures the returned word into the instruction register that feeds the control unit, and applies jump redirects and link-address capture commanded by the control unit.

## Interface
- ADDR_W, 16: PC / ROM address width
- RESET_PC, 0: PC value after reset
- TIMEOUT, 15: max cycles in REQ+WAIT before a fetch is abandoned (≥1)

- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- fetch_req  in  1  one-cycle pulse from control unit (PC-advance strobe): start a fetch
- jump_en  in  1  one-cycle pulse: load PC from jump_target
- jump_target  in  ADDR_W  redirect address (ULA result / register B)
- link_en  in  1  one-cycle pulse: capture current PC into pc_link
- rom_addr  out  ADDR_W  ROM address
- rom_cen  out  1  ROM chip enable
- rom_ren  out  1  ROM read enable
- rom_data  in  16  ROM read data
- rom_valid  in  1  rom_data valid this cycle
- instrucao  out  16  instruction register to control unit
- instr_valid  out  1  one-cycle pulse: instrucao updated
- pc  out  ADDR_W  current PC (address of next instruction to fetch)
- pc_link  out  ADDR_W  return address for jump-and-link (written to R7)
- busy  out  1  high whenever state ≠ IDLE
- fetch_fault  out  1  sticky: a fetch timed out

## Operation
- States: IDLE, REQ, WAIT.
- IDLE: fetch_req → REQ. Otherwise stay.
- REQ (exactly one cycle): rom_cen=rom_ren=1, rom_addr=pc. rom_valid → complete; else → WAIT.
- WAIT: rom_cen=rom_ren=0, rom_addr holds pc. rom_valid → complete; timeout → abandon.
- Complete: instrucao<=rom_data, instr_valid=1 next cycle, pc<=next_pc, → IDLE.
- next_pc: pending jump ? latched target : pc+1, modulo 2^ADDR_W (all-ones wraps to 0).
- jump_en in IDLE: pc<=jump_target immediately. jump_en in REQ/WAIT: target latched, pending=1; applied at completion or abandon; later jump_en overwrites earlier pending target.
- fetch_req and jump_en same IDLE cycle: pc<=jump_target; fetch in REQ uses new pc.
- fetch_req while busy: ignored (no queueing).
- link_en: pc_link<=pc (pc already = address after current instruction). Same-cycle link_en and jump_en: pc_link takes old pc.
- Timeout: cycle counter cleared on entering REQ, increments each REQ/WAIT cycle without rom_valid; reaching TIMEOUT → IDLE, fetch_fault<=1, instrucao and instr_valid unchanged/0, pc unchanged unless a jump is pending (then loaded).
- rom_valid in IDLE ignored.

## Timing
- Reset values: pc=RESET_PC, instrucao=16'h0000, pc_link=0, instr_valid=0, rom_cen=rom_ren=0, rom_addr=RESET_PC, busy=0, fetch_fault=0, pending=0, state IDLE.
- Reset mid-fetch aborts; a late rom_valid after reset is ignored.
- fetch_req at cycle 0 → REQ at cycle 1. rom_valid at cycle k (k≥1) → instrucao/instr_valid/pc update visible at cycle k+1, state IDLE at k+1. Minimum latency 2 cycles.
- Next fetch_req accepted in the cycle instr_valid is high.
- All outputs registered except rom_addr (= pc).

## Structure
- Package fetch_pkg: state enum (IDLE, REQ, WAIT), default RESET_PC, TIMEOUT default, instruction width 16.
- One sub-module: pc_reg (PC register, +1 incrementer with wrap, jump load, pending-target latch).

## Test plan
- Reset, fetch_req, rom_valid at REQ with rom_data=16'h8A53 → instrucao=16'h8A53, instr_valid one cycle at cycle 2, pc 0→1.
- ROM latency 4 (rom_valid cycle 4), data 16'h4123 → instr_valid at cycle 5, busy cycles 1–4, no early update.
- jump_en target 16'h0040 in IDLE then fetch_req → rom_addr=16'h0040 in REQ, pc=16'h0041 after completion; jump_en 16'h0100 during WAIT → pc=16'h0100 after completion.
- pc=16'hFFFF, fetch completes → pc=16'h0000; link_en at pc=16'h0012 → pc_link=16'h0012.
- No rom_valid for TIMEOUT=15 cycles → IDLE, fetch_fault=1 stays set, instrucao unchanged, pc unchanged; subsequent normal fetch succeeds.
- reset asserted in WAIT, rom_valid next cycle → all outputs at reset values, instr_valid stays 0.
